// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ctrl_pkg
//  Purpose  : Shared types, opcode constants and IR field positions for the
//             instruction sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_RD_A  = 4'd1,
    S_RD_B  = 4'd2,
    S_EXEC  = 4'd3,
    S_WB    = 4'd4,
    S_WBF   = 4'd5,
    S_LD_WR = 4'd6,
    S_FIN   = 4'd7,
    S_ILL   = 4'd8
  } state_t;

  typedef enum logic [1:0] {
    CLS_ALU  = 2'd0,
    CLS_LOAD = 2'd1,
    CLS_NOP  = 2'd2,
    CLS_ILL  = 2'd3
  } iclass_t;

  localparam logic [3:0] OP_LOAD = 4'b1000;
  localparam logic [3:0] OP_NOP  = 4'b1001;

  localparam logic [2:0] FLAG_ADDR_DEFAULT = 3'd7;

  localparam int OP_HI   = 14;
  localparam int OP_LO   = 12;
  localparam int DST_HI  = 9;
  localparam int DST_LO  = 8;
  localparam int SRCA_HI = 5;
  localparam int SRCA_LO = 4;
  localparam int SRCB_HI = 1;
  localparam int SRCB_LO = 0;

  // Class is fully determined by the top nibble of the instruction word.
  function automatic iclass_t classify(input logic [3:0] opc);
    iclass_t c;
    if (!opc[3])              c = CLS_ALU;
    else if (opc == OP_LOAD)  c = CLS_LOAD;
    else if (opc == OP_NOP)   c = CLS_NOP;
    else                      c = CLS_ILL;
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : instr_sequencer_if
//  Purpose  : Instruction handshake, register-file and ALU signals of the
//             sequencer, with sequencer (master) and datapath (slave) views.
//  Revision : 1.0 - initial release
// ============================================================================
interface instr_sequencer_if #(
  parameter int DW = 8
);
  logic [15:0]   ir_data;
  logic          ir_valid;
  logic          ir_ready;
  logic [2:0]    rf_addr;
  logic          rf_rd;
  logic          rf_wr;
  logic [DW-1:0] rf_wdata;
  logic [DW-1:0] rf_rdata;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [2:0]    alu_op;
  logic [DW-1:0] alu_result;
  logic          alu_cy;
  logic          alu_zero;
  logic          done;
  logic          illegal;

  modport master (
    input  ir_data, ir_valid, rf_rdata, alu_result, alu_cy, alu_zero,
    output ir_ready, rf_addr, rf_rd, rf_wr, rf_wdata, alu_a, alu_b, alu_op,
           done, illegal
  );

  modport slave (
    output ir_data, ir_valid, rf_rdata, alu_result, alu_cy, alu_zero,
    input  ir_ready, rf_addr, rf_rd, rf_wr, rf_wdata, alu_a, alu_b, alu_op,
           done, illegal
  );
endinterface
`default_nettype wire

// File: rtl/instr_decode.sv
`default_nettype none
// ============================================================================
//  Module   : instr_decode
//  Purpose  : Combinational field extraction of a 16-bit instruction word.
//  Revision : 1.0 - initial release
// ============================================================================
module instr_decode
  import ctrl_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [15:0]   ir,
  output iclass_t       cls,
  output logic [2:0]    dst,
  output logic [2:0]    src_a,
  output logic [2:0]    src_b,
  output logic [2:0]    alu_op,
  output logic [DW-1:0] imm
);

  logic unused_ir;

  assign cls    = classify(ir[15:12]);
  assign dst    = {1'b0, ir[DST_HI:DST_LO]};
  assign src_a  = {1'b0, ir[SRCA_HI:SRCA_LO]};
  assign src_b  = {1'b0, ir[SRCB_HI:SRCB_LO]};
  assign alu_op = ir[OP_HI:OP_LO];
  // Pad bits between fields carry no meaning.
  assign unused_ir = ^ir;

  generate
    if (DW <= 16) begin : g_imm_trunc
      assign imm = ir[DW-1:0];
    end else begin : g_imm_ext
      assign imm = {{(DW-16){1'b0}}, ir};
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : instr_sequencer
//  Purpose  : Multi-cycle FSM that fetches, decodes and steps one instruction
//             through the register file and ALU, one step per clock.
//  Revision : 1.0 - initial release
// ============================================================================
module instr_sequencer
  import ctrl_pkg::*;
#(
  parameter int         DW        = 8,
  parameter logic [2:0] FLAG_ADDR = FLAG_ADDR_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  instr_sequencer_if.master  bus
);

  state_t        r_state;
  state_t        w_next;
  logic [15:0]   r_ir;
  logic [15:0]   w_ir;
  logic [2:0]    r_alu_op;
  logic [DW-1:0] r_alu_a;
  logic [DW-1:0] r_alu_b;
  logic          r_cy;
  logic          r_zero;

  iclass_t       w_cls;
  logic [2:0]    w_dst;
  logic [2:0]    w_src_a;
  logic [2:0]    w_src_b;
  logic [2:0]    w_alu_op;
  logic [DW-1:0] w_imm;
  logic [DW-1:0] w_flags;

  logic          w_ir_ready;
  logic          w_rf_rd;
  logic          w_rf_wr;
  logic [2:0]    w_rf_addr;
  logic [DW-1:0] w_rf_wdata;
  logic          w_done;
  logic          w_illegal;
  logic          w_accept;

  // In IDLE the live word picks the next state; afterwards the latched copy drives the fields.
  assign w_ir     = (r_state == S_IDLE) ? bus.ir_data : r_ir;
  assign w_accept = w_ir_ready & bus.ir_valid;

  instr_decode #(.DW(DW)) u_decode (
    .ir     (w_ir),
    .cls    (w_cls),
    .dst    (w_dst),
    .src_a  (w_src_a),
    .src_b  (w_src_b),
    .alu_op (w_alu_op),
    .imm    (w_imm)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_ir     <= '0;
      r_alu_op <= '0;
      r_alu_a  <= '0;
      r_alu_b  <= '0;
      r_cy     <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_ir     <= bus.ir_data;
        r_alu_op <= w_alu_op;
      end
      if (r_state == S_RD_B) r_alu_a <= bus.rf_rdata;
      if (r_state == S_EXEC) r_alu_b <= bus.rf_rdata;
      if (r_state == S_WB) begin
        r_cy   <= bus.alu_cy;
        r_zero <= bus.alu_zero;
      end
    end
  end

  always_comb begin
    w_next          = r_state;
    w_ir_ready      = 1'b0;
    w_rf_rd         = 1'b0;
    w_rf_wr         = 1'b0;
    w_rf_addr       = '0;
    w_rf_wdata      = '0;
    w_done          = 1'b0;
    w_illegal       = 1'b0;
    w_flags         = '0;
    w_flags[DW-1]   = r_cy;
    w_flags[DW-2]   = r_zero;
    case (r_state)
      S_IDLE: begin
        w_ir_ready = 1'b1;
        if (bus.ir_valid) begin
          case (w_cls)
            CLS_ALU:  w_next = S_RD_A;
            CLS_LOAD: w_next = S_LD_WR;
            CLS_NOP:  w_next = S_FIN;
            default:  w_next = S_ILL;
          endcase
        end
      end
      S_RD_A: begin
        w_rf_rd   = 1'b1;
        w_rf_addr = w_src_a;
        w_next    = S_RD_B;
      end
      S_RD_B: begin
        w_rf_rd   = 1'b1;
        w_rf_addr = w_src_b;
        w_next    = S_EXEC;
      end
      S_EXEC: w_next = S_WB;
      S_WB: begin
        w_rf_wr    = 1'b1;
        w_rf_addr  = w_dst;
        w_rf_wdata = bus.alu_result;
        w_next     = S_WBF;
      end
      S_WBF: begin
        w_rf_wr    = 1'b1;
        w_rf_addr  = FLAG_ADDR;
        w_rf_wdata = w_flags;
        w_done     = 1'b1;
        w_next     = S_IDLE;
      end
      S_LD_WR: begin
        w_rf_wr    = 1'b1;
        w_rf_addr  = w_dst;
        w_rf_wdata = w_imm;
        w_done     = 1'b1;
        w_next     = S_IDLE;
      end
      S_FIN: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      S_ILL: begin
        w_illegal = 1'b1;
        w_done    = 1'b1;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign bus.ir_ready = w_ir_ready;
  assign bus.rf_rd    = w_rf_rd;
  assign bus.rf_wr    = w_rf_wr;
  assign bus.rf_addr  = w_rf_addr;
  assign bus.rf_wdata = w_rf_wdata;
  assign bus.done     = w_done;
  assign bus.illegal  = w_illegal;
  assign bus.alu_a    = r_alu_a;
  assign bus.alu_b    = r_alu_b;
  assign bus.alu_op   = r_alu_op;

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_sequencer
//  Purpose  : Self-checking bench for instr_sequencer with a register-file and
//             ALU datapath and an instruction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instr_sequencer;

  localparam int DW = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int vectors     = 0;
  int miscompares = 0;

  logic [DW-1:0] rf   [8];
  logic [DW-1:0] mref [8];
  logic [DW-1:0] rdata_q = '0;
  logic [8:0]    alu_w;

  instr_sequencer_if #(.DW(DW)) bus ();

  instr_sequencer #(.DW(DW), .FLAG_ADDR(3'd7)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Returns {carry, result}.
  function automatic logic [8:0] alu_ref(input logic [2:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
    logic [8:0] r;
    case (op)
      3'd0:    r = {1'b0, a} + {1'b0, b};
      3'd1:    r = {1'b0, a} - {1'b0, b};
      3'd2:    r = {1'b0, a & b};
      3'd3:    r = {1'b0, a | b};
      3'd4:    r = {1'b0, a ^ b};
      3'd5:    r = {a[7], a[6:0], 1'b0};
      3'd6:    r = {a[0], 1'b0, a[7:1]};
      default: r = {1'b0, ~a};
    endcase
    return r;
  endfunction

  // Datapath around the DUT: combinational ALU and sync-read/sync-write register file.
  assign alu_w          = alu_ref(bus.alu_op, bus.alu_a, bus.alu_b);
  assign bus.alu_result = alu_w[7:0];
  assign bus.alu_cy     = alu_w[8];
  assign bus.alu_zero   = (alu_w[7:0] == 8'h00);
  assign bus.rf_rdata   = rdata_q;

  always @(posedge clk) begin
    if (bus.rf_wr) rf[bus.rf_addr] <= bus.rf_wdata;
    if (bus.rf_rd) rdata_q <= rf[bus.rf_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one instruction and check its whole execution against the model.
  task automatic run_instr(input logic [15:0] ir, input bit b2b, input bit hold);
    int         exp_lat, exp_rd, exp_ill, exp_n;
    int         exp_c [2];
    logic [2:0] exp_a [2];
    logic [7:0] exp_d [2];
    int         obs_c [4];
    logic [2:0] obs_a [4];
    logic [7:0] obs_d [4];
    int         obs_n, obs_rd, obs_ill, busy_rdy, waitc, cyc;
    bit         done_seen;
    logic [8:0] r;
    logic [2:0] d, sa, sb;
    logic [7:0] opa, opb;

    exp_n = 0; exp_rd = 0; exp_ill = 0; exp_lat = 1;
    exp_c[0] = 0; exp_c[1] = 0; exp_a[0] = 0; exp_a[1] = 0; exp_d[0] = 0; exp_d[1] = 0;
    d   = {1'b0, ir[9:8]};
    sa  = {1'b0, ir[5:4]};
    sb  = {1'b0, ir[1:0]};
    opa = mref[sa];
    opb = mref[sb];
    if (ir[15] == 1'b0) begin
      r        = alu_ref(ir[14:12], opa, opb);
      exp_lat  = 5; exp_rd = 2; exp_n = 2;
      exp_c[0] = 4; exp_a[0] = d;    exp_d[0] = r[7:0];
      exp_c[1] = 5; exp_a[1] = 3'd7; exp_d[1] = {r[8], (r[7:0] == 8'h00), 6'b0};
      mref[d]  = r[7:0];
      mref[7]  = exp_d[1];
    end else if (ir[14:12] == 3'b000) begin
      exp_n    = 1;
      exp_c[0] = 1; exp_a[0] = d; exp_d[0] = ir[7:0];
      mref[d]  = ir[7:0];
    end else if (ir[14:12] != 3'b001) begin
      exp_ill = 1;
    end

    if (!b2b) begin
      bus.ir_valid = 1'b0;
      @(negedge clk);
    end
    bus.ir_data  = ir;
    bus.ir_valid = 1'b1;
    waitc = 0;
    while (bus.ir_ready !== 1'b1 && waitc < 8) begin
      @(negedge clk);
      waitc++;
    end
    chk("accept_wait", waitc, b2b ? 1 : 0);

    @(posedge clk);
    #1;
    if (!hold) bus.ir_valid = 1'b0;
    obs_n = 0; obs_rd = 0; obs_ill = 0; busy_rdy = 0; done_seen = 0; cyc = 0;
    while (!done_seen && cyc < 8) begin
      @(negedge clk);
      cyc++;
      if (bus.ir_ready) busy_rdy++;
      if (bus.rf_rd)    obs_rd++;
      if (bus.illegal)  obs_ill++;
      if (bus.rf_wr && obs_n < 4) begin
        obs_c[obs_n] = cyc;
        obs_a[obs_n] = bus.rf_addr;
        obs_d[obs_n] = bus.rf_wdata;
        obs_n++;
      end
      if (bus.done) done_seen = 1;
    end
    chk("done_seen", done_seen, 1);
    chk("done_latency", cyc, exp_lat);
    chk("ready_while_busy", busy_rdy, 0);
    chk("read_count", obs_rd, exp_rd);
    chk("illegal_pulses", obs_ill, exp_ill);
    chk("write_count", obs_n, exp_n);
    for (int i = 0; i < exp_n && i < obs_n; i++) begin
      chk("write_cycle", obs_c[i], exp_c[i]);
      chk("write_addr", obs_a[i], exp_a[i]);
      chk("write_data", obs_d[i], exp_d[i]);
    end
    if (exp_rd == 2) begin
      chk("alu_a", bus.alu_a, opa);
      chk("alu_b", bus.alu_b, opb);
      chk("alu_op", bus.alu_op, ir[14:12]);
    end
  endtask

  initial begin
    logic [15:0] ir;
    logic [15:0] junk;
    int          k, cnt;

    for (int i = 0; i < 8; i++) mref[i] = 8'h00;
    bus.ir_data  = 16'h7777;
    bus.ir_valid = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_ir_ready", bus.ir_ready, 1);
    chk("rst_rf_rd", bus.rf_rd, 0);
    chk("rst_rf_wr", bus.rf_wr, 0);
    chk("rst_rf_addr", bus.rf_addr, 0);
    chk("rst_rf_wdata", bus.rf_wdata, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_illegal", bus.illegal, 0);
    chk("rst_alu_a", bus.alu_a, 0);
    chk("rst_alu_b", bus.alu_b, 0);
    chk("rst_alu_op", bus.alu_op, 0);
    bus.ir_valid = 1'b0;
    rst_n = 1'b1;

    run_instr(16'h825A, 0, 0);
    run_instr(16'h8080, 0, 0);
    run_instr(16'h8390, 0, 0);
    run_instr(16'h0103, 0, 0);
    run_instr(16'h8000, 0, 0);
    chk("add_dst_reg", rf[1], 8'h10);
    chk("add_flag_reg", rf[7], 8'h80);
    run_instr(16'h8300, 0, 0);
    run_instr(16'h0103, 0, 0);
    run_instr(16'h9000, 0, 0);
    chk("zero_dst_reg", rf[1], 8'h00);
    chk("zero_flag_reg", rf[7], 8'h40);
    run_instr(16'hF000, 0, 0);
    run_instr(16'hA5C3, 0, 0);

    // Back-to-back with ir_valid held high across instructions.
    run_instr(16'h8133, 0, 1);
    run_instr(16'h0012, 1, 1);
    run_instr(16'h8277, 1, 1);
    run_instr(16'h9ABC, 1, 0);

    for (int n = 0; n < 40; n++) begin
      k    = $urandom_range(0, 9);
      junk = 16'($urandom);
      if (k < 5)       ir = {1'b0, junk[14:0]};
      else if (k < 7)  ir = {4'b1000, junk[11:0]};
      else if (k < 8)  ir = {4'b1001, junk[11:0]};
      else             ir = {1'b1, 3'($urandom_range(2, 7)), junk[11:0]};
      run_instr(ir, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Reset asserted while the destination write is being driven.
    bus.ir_valid = 1'b0;
    @(negedge clk);
    bus.ir_data  = 16'h0203;
    bus.ir_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.ir_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("midop_wb_active", bus.rf_wr, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("midop_async_wr", bus.rf_wr, 0);
    chk("midop_async_rd", bus.rf_rd, 0);
    chk("midop_ready", bus.ir_ready, 1);
    chk("midop_alu_a", bus.alu_a, 0);
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done || bus.rf_wr) cnt++;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bus.done || bus.rf_wr) cnt++;
    end
    chk("midop_no_done_or_write", cnt, 0);
    chk("midop_ready_after", bus.ir_ready, 1);
    chk("midop_flag_kept", rf[7], mref[7]);
    chk("midop_dst_kept", rf[2], mref[2]);

    run_instr(16'h81C4, 0, 0);
    run_instr(16'h0711, 0, 0);
    run_instr(16'h9000, 0, 0);

    for (int i = 0; i < 4; i++) chk("final_reg", rf[i], mref[i]);
    chk("final_flag_reg", rf[7], mref[7]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
